// File: rtl/hamming_mem_engine.sv
// SECDED (16,11) Hamming engine that walks a block of messages in data memory.
// Each message is read as two bytes, encoded or decoded, and written back as two bytes.
// Handshake: start_i is a one-cycle request taken only in IDLE or DONE; busy_o is high
// from the accepting edge until DONE; done_o then holds until the next accepted start.
module hamming_mem_engine #(
    parameter int NUM_MSG  = 15,
    parameter int SRC_BASE = 0,
    parameter int DST_BASE = 30,
    parameter int AW       = 8
) (
    input  logic          clk_i,
    input  logic          reset_i,
    input  logic          start_i,
    input  logic          mode_i,
    output logic [AW-1:0] mem_addr_o,
    input  logic [7:0]    mem_rd_data_i,
    output logic          mem_wr_en_o,
    output logic [7:0]    mem_wr_data_o,
    output logic          busy_o,
    output logic          done_o,
    output logic [7:0]    err1_cnt_o,
    output logic [7:0]    err2_cnt_o,
    output logic [2:0]    state_o
);

    localparam int IW = (NUM_MSG > 1) ? $clog2(NUM_MSG) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_RD_LO, S_RD_HI, S_WR_LO, S_WR_HI, S_DONE
    } state_t;

    state_t        state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;
    logic          mode_q, mode_d;
    logic [7:0]    lo_q, lo_d, hi_q, hi_d;
    logic [7:0]    err1_q, err1_d, err2_q, err2_d;

    logic [AW-1:0] src_lo, dst_lo;
    logic [10:0]   enc_d;
    logic [15:0]   enc_base, enc_w;
    logic          p1, p2, p4, p8;
    logic [15:0]   dec_w, dec_wc;
    logic [3:0]    dec_s;
    logic          dec_p;
    logic [1:0]    dec_f;
    logic [10:0]   dec_data;
    logic [7:0]    res_lo, res_hi;

    assign src_lo  = AW'(SRC_BASE) + AW'({idx_q, 1'b0});
    assign dst_lo  = AW'(DST_BASE) + AW'({idx_q, 1'b0});
    assign state_o = state_q;

    // Encoder: place data bits, then fill parity positions so every syndrome bit is zero.
    always_comb begin
        enc_d    = {hi_q[2:0], lo_q};
        enc_base = {enc_d[10:4], 1'b0, enc_d[3:1], 1'b0, enc_d[0], 3'b000};
        p1       = ^(enc_base & 16'hAAAA);
        p2       = ^(enc_base & 16'hCCCC);
        p4       = ^(enc_base & 16'hF0F0);
        p8       = ^(enc_base & 16'hFF00);
        enc_w    = enc_base | {7'b0, p8, 3'b0, p4, 1'b0, p2, p1, 1'b0};
        enc_w[0] = ^enc_w[15:1];
    end

    // Decoder: syndrome bit b is the parity of all positions whose index has bit b set.
    always_comb begin
        dec_w  = {hi_q, lo_q};
        dec_s  = {^(dec_w & 16'hFF00), ^(dec_w & 16'hF0F0),
                  ^(dec_w & 16'hCCCC), ^(dec_w & 16'hAAAA)};
        dec_p  = ^dec_w;
        dec_wc = dec_w;
        dec_f  = 2'b00;
        if (dec_p) begin
            dec_wc = dec_w ^ (16'd1 << dec_s);
            dec_f  = 2'b01;
        end else if (dec_s != 4'd0) begin
            dec_f  = 2'b10;
        end
        dec_data = {dec_wc[15:9], dec_wc[7:5], dec_wc[3]};
    end

    // Result bytes for the latched mode, always taken from the captured source bytes.
    always_comb begin
        if (mode_q) begin
            res_lo = dec_data[7:0];
            res_hi = {dec_f, 3'b000, dec_data[10:8]};
        end else begin
            res_lo = enc_w[7:0];
            res_hi = enc_w[15:8];
        end
    end

    // State, index, mode, captured bytes and error counters.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            mode_q  <= 1'b0;
            lo_q    <= '0;
            hi_q    <= '0;
            err1_q  <= '0;
            err2_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            mode_q  <= mode_d;
            lo_q    <= lo_d;
            hi_q    <= hi_d;
            err1_q  <= err1_d;
            err2_q  <= err2_d;
        end
    end

    // Next-state sequencing and per-state memory port outputs.
    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        mode_d        = mode_q;
        lo_d          = lo_q;
        hi_d          = hi_q;
        err1_d        = err1_q;
        err2_d        = err2_q;
        mem_addr_o    = '0;
        mem_wr_en_o   = 1'b0;
        mem_wr_data_o = 8'h00;
        busy_o        = 1'b0;
        done_o        = 1'b0;
        case (state_q)
            S_IDLE, S_DONE: begin
                done_o = (state_q == S_DONE);
                if (start_i) begin
                    state_d = S_RD_LO;
                    idx_d   = '0;
                    mode_d  = mode_i;
                    err1_d  = '0;
                    err2_d  = '0;
                end
            end
            S_RD_LO: begin
                busy_o     = 1'b1;
                mem_addr_o = src_lo;
                lo_d       = mem_rd_data_i;
                state_d    = S_RD_HI;
            end
            S_RD_HI: begin
                busy_o     = 1'b1;
                mem_addr_o = src_lo + AW'(1);
                hi_d       = mem_rd_data_i;
                state_d    = S_WR_LO;
            end
            S_WR_LO: begin
                busy_o        = 1'b1;
                mem_addr_o    = dst_lo;
                mem_wr_en_o   = 1'b1;
                mem_wr_data_o = res_lo;
                if (mode_q && dec_f == 2'b01 && err1_q != 8'hFF) err1_d = err1_q + 8'd1;
                if (mode_q && dec_f == 2'b10 && err2_q != 8'hFF) err2_d = err2_q + 8'd1;
                state_d       = S_WR_HI;
            end
            S_WR_HI: begin
                busy_o        = 1'b1;
                mem_addr_o    = dst_lo + AW'(1);
                mem_wr_en_o   = 1'b1;
                mem_wr_data_o = res_hi;
                if (idx_q == IW'(NUM_MSG - 1)) begin
                    state_d = S_DONE;
                end else begin
                    idx_d   = idx_q + IW'(1);
                    state_d = S_RD_LO;
                end
            end
            default: state_d = S_IDLE;
        endcase
        // A reset in a write cycle must not let that final byte land.
        if (reset_i) mem_wr_en_o = 1'b0;
    end

    assign err1_cnt_o = err1_q;
    assign err2_cnt_o = err2_q;

endmodule

// File: tb/tb_hamming_mem_engine.sv
// Bench for hamming_mem_engine: byte memory model, directed and random message blocks,
// reference encode/decode computed from the Hamming index rules.
module tb_hamming_mem_engine;

    localparam int N   = 15;
    localparam int SRC = 0;
    localparam int DST = 30;

    logic       clk = 1'b0;
    logic       reset, start, mode;
    logic [7:0] mem_addr, mem_rd_data, mem_wr_data, err1_cnt, err2_cnt;
    logic       mem_wr_en, busy, done;
    logic [2:0] state_dbg;

    logic [7:0] mem [256];
    logic       tb_load;
    logic [7:0] tb_la, tb_ld;

    int n_assert = 0;
    int n_fail   = 0;

    logic [15:0] src_w [N];
    logic [15:0] exp_q [$];
    int          exp_e1, exp_e2;

    hamming_mem_engine dut (
        .clk_i(clk), .reset_i(reset), .start_i(start), .mode_i(mode),
        .mem_addr_o(mem_addr), .mem_rd_data_i(mem_rd_data),
        .mem_wr_en_o(mem_wr_en), .mem_wr_data_o(mem_wr_data),
        .busy_o(busy), .done_o(done),
        .err1_cnt_o(err1_cnt), .err2_cnt_o(err2_cnt), .state_o(state_dbg)
    );

    always #5 clk = ~clk;

    assign mem_rd_data = mem[mem_addr];

    always @(posedge clk) begin
        if (tb_load) mem[tb_la] <= tb_ld;
        else if (mem_wr_en) mem[mem_addr] <= mem_wr_data;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Reference encode: data fills non-power-of-two positions in order; parity bit 2^b
    // is bit b of the XOR of data-bit indices, which drives the syndrome to zero.
    function automatic logic [15:0] model_encode(input logic [10:0] d);
        logic [15:0] w;
        int k, s;
        w = '0; k = 0; s = 0;
        for (int i = 1; i < 16; i++) begin
            if ((i & (i - 1)) != 0) begin
                w[i] = d[k];
                if (d[k]) s = s ^ i;
                k++;
            end
        end
        for (int b = 0; b < 4; b++) w[1 << b] = s[b];
        w[0] = ^w[15:1];
        return w;
    endfunction

    // Reference decode: returns {hi, lo} result bytes and the flag.
    function automatic logic [15:0] model_decode(input logic [15:0] w_in, output int f);
        logic [15:0] w;
        logic [10:0] d;
        int s, k;
        w = w_in; s = 0; k = 0; d = '0;
        for (int i = 1; i < 16; i++) if (w[i]) s = s ^ i;
        if (^w) begin
            w[s] = ~w[s];
            f = 1;
        end else if (s != 0) begin
            f = 2;
        end else begin
            f = 0;
        end
        for (int i = 1; i < 16; i++) begin
            if ((i & (i - 1)) != 0) begin
                d[k] = w[i];
                k++;
            end
        end
        return {2'(f), 3'b000, d[10:8], d[7:0]};
    endfunction

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic write_byte(input int a, input logic [7:0] d);
        tb_load = 1'b1; tb_la = 8'(a); tb_ld = d;
        tick();
        tb_load = 1'b0;
    endtask

    task automatic load_src();
        for (int i = 0; i < N; i++) begin
            write_byte(SRC + 2 * i, src_w[i][7:0]);
            write_byte(SRC + 2 * i + 1, src_w[i][15:8]);
        end
    endtask

    task automatic build_expect(input logic m);
        int f;
        exp_q.delete();
        exp_e1 = 0; exp_e2 = 0;
        for (int i = 0; i < N; i++) begin
            if (m) begin
                exp_q.push_back(model_decode(src_w[i], f));
                if (f == 1) exp_e1++;
                if (f == 2) exp_e2++;
            end else begin
                exp_q.push_back(model_encode({src_w[i][10:8], src_w[i][7:0]}));
            end
        end
    endtask

    // Starts a run and follows it to done; optionally pulses start (other mode) mid-run.
    task automatic run_job(input logic m, input int inject_at, output int cyc, output int bcnt);
        mode = m; start = 1'b1;
        tick();
        start = 1'b0;
        cyc = 0; bcnt = 0;
        while (cyc < 300) begin
            if (busy) bcnt++;
            if (done) break;
            if (cyc == inject_at) begin start = 1'b1; mode = ~m; end
            else begin start = 1'b0; mode = m; end
            tick();
            cyc++;
        end
        start = 1'b0; mode = m;
    endtask

    task automatic run_and_check(input string tag, input logic m, input int inject_at);
        int cyc, bcnt;
        logic [15:0] e;
        build_expect(m);
        run_job(m, inject_at, cyc, bcnt);
        check({tag, "_latency"}, 32'(cyc), 32'd60);
        check({tag, "_busy_cycles"}, 32'(bcnt), 32'd60);
        check({tag, "_done_idle_port"}, {29'd0, done, mem_wr_en, busy}, 32'h4);
        for (int i = 0; i < N; i++) begin
            e = exp_q.pop_front();
            check($sformatf("%s_msg%0d", tag, i),
                  {16'd0, mem[DST + 2 * i + 1], mem[DST + 2 * i]}, {16'd0, e});
        end
        check({tag, "_err1"}, 32'(err1_cnt), 32'(exp_e1));
        check({tag, "_err2"}, 32'(err2_cnt), 32'(exp_e2));
    endtask

    initial begin
        logic [10:0] data [N];
        int wr_seen;
        reset = 1'b1; start = 1'b0; mode = 1'b0;
        tb_load = 1'b0; tb_la = '0; tb_ld = '0;
        for (int a = 0; a < 256; a++) mem[a] = 8'h00;
        repeat (3) tick();
        check("reset_outputs", {mem_addr, mem_wr_data, err1_cnt, err2_cnt}, 32'd0);
        check("reset_flags", {29'd0, busy, done, mem_wr_en}, 32'd0);
        reset = 1'b0;
        tick();

        // Directed encode: 0x001 -> 0x000F, 0x000 -> 0x0000, hi[7:3] junk on the rest.
        src_w[0] = 16'h0001;
        src_w[1] = 16'h0000;
        for (int i = 2; i < N; i++) src_w[i] = 16'($urandom);
        load_src();
        run_and_check("enc_dir", 1'b0, -1);
        check("enc_0x001", {mem[DST + 1], mem[DST]}, 32'h000F);
        check("enc_0x000", {mem[DST + 3], mem[DST + 2]}, 32'h0000);

        // Directed decode: clean, d5 flip, p0 flip, double error; random words after.
        src_w[0] = 16'h000F;
        src_w[1] = 16'h020F;
        src_w[2] = 16'h000E;
        src_w[3] = 16'h060F;
        for (int i = 4; i < N; i++) src_w[i] = 16'($urandom);
        load_src();
        run_and_check("dec_dir", 1'b1, -1);
        check("dec_clean", {mem[DST + 1], mem[DST]}, 32'h0001);
        check("dec_d5", {mem[DST + 3], mem[DST + 2]}, 32'h4001);
        check("dec_p0", {mem[DST + 5], mem[DST + 4]}, 32'h4001);
        check("dec_double", {mem[DST + 7], mem[DST + 6]}, 32'h8031);

        // Random round trip: encode, then decode with one random bit flipped per word.
        for (int i = 0; i < N; i++) begin
            data[i]  = 11'($urandom);
            src_w[i] = {5'($urandom), data[i]};
        end
        load_src();
        run_and_check("enc_rand", 1'b0, -1);
        for (int i = 0; i < N; i++)
            src_w[i] = model_encode(data[i]) ^ (16'd1 << $urandom_range(15, 0));
        load_src();
        run_and_check("dec_rand", 1'b1, -1);
        for (int i = 0; i < N; i++)
            check($sformatf("recover_%0d", i), {mem[DST + 2 * i + 1], mem[DST + 2 * i]},
                  {16'd0, 2'b01, 3'b000, data[i]});
        check("recover_err1", 32'(err1_cnt), 32'd15);

        // Reset in cycle 10 of a run: back to idle, no writes afterwards.
        mode = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (9) tick();
        reset = 1'b1;
        wr_seen = 0;
        if (mem_wr_en) wr_seen++;
        tick();
        reset = 1'b0;
        check("rst_mid_flags", {30'd0, busy, done}, 32'd0);
        check("rst_mid_port", {16'd0, mem_addr, mem_wr_data}, 32'd0);
        for (int c = 0; c < 12; c++) begin
            if (mem_wr_en) wr_seen++;
            tick();
        end
        check("rst_mid_no_writes", 32'(wr_seen), 32'd0);

        // Full run after the reset, with start pulsed mid-run in the other mode.
        for (int i = 0; i < N; i++) src_w[i] = 16'($urandom);
        load_src();
        run_and_check("after_rst_inject", 1'b1, 20);

        // done holds while idle.
        repeat (7) tick();
        check("done_held", {31'd0, done}, 32'd1);

        // start and reset together: reset wins.
        start = 1'b1; mode = 1'b0; reset = 1'b1;
        tick();
        start = 1'b0; reset = 1'b0;
        check("start_reset_same", {30'd0, busy, done}, 32'd0);
        tick();
        check("start_reset_stays_idle", {30'd0, busy, done}, 32'd0);

        // A clean encode run to finish, with a mid-run start that must be ignored.
        for (int i = 0; i < N; i++) src_w[i] = 16'($urandom);
        load_src();
        run_and_check("final_enc_inject", 1'b0, 5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
